// File: rtl/barret_rr_scheduler_if.sv
// ---------------------------------------------------------------------------
// barret_rr_scheduler_if
// Handshake bundle between N_REQ operand producers, the shared Barrett
// reduction scheduler and the downstream residue consumer.
//   req_valid / req_data / req_ready : per-requester operand offer and accept
//   res_valid / res_data / res_id / res_ready : tagged residue output
//   idle : both reducer stages empty
// master = producer/consumer side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface barret_rr_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int W_IN  = 23,
    parameter int W_OUT = 12,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*W_IN-1:0] req_data;
    logic [N_REQ-1:0]      req_ready;
    logic                  res_valid;
    logic [W_OUT-1:0]      res_data;
    logic [ID_W-1:0]       res_id;
    logic                  res_ready;
    logic                  idle;

    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_data, res_id, idle
    );

    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_data, res_id, idle
    );
endinterface

// File: rtl/barret_rr_scheduler.sv
// ---------------------------------------------------------------------------
// barret_rr_scheduler
// Round-robin arbiter in front of a two-stage pipelined Barrett reducer.
// One operand per cycle is accepted from the requester chosen by a rotating
// pointer; its residue mod Q leaves two cycles later, tagged with the index
// of the requester that supplied it. Results leave in acceptance order.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   s_bus  : barret_rr_scheduler_if.slave (requests, results, idle)
// ---------------------------------------------------------------------------
module barret_rr_scheduler #(
    parameter int Q     = 2213,
    parameter int MU    = 7581,
    parameter int K     = 12,
    parameter int W_IN  = 23,
    parameter int W_OUT = 12,
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    barret_rr_scheduler_if.slave   s_bus
);

    // Datapath widths derived from the constants so the quotient estimate
    // product is never truncated.
    localparam int W_Q1   = W_IN - K;
    localparam int W_MU   = $clog2(MU + 1);
    localparam int W_PROD = W_Q1 + W_MU;
    localparam int W_T    = W_PROD - K;
    localparam int W_TQ   = W_T + W_OUT;
    localparam int W_R    = W_OUT + 2;

    logic [ID_W-1:0]  r_ptr;
    logic             r_s1_valid;
    logic [W_Q1-1:0]  r_s1_q;
    logic [W_IN-1:0]  r_s1_a;
    logic [ID_W-1:0]  r_s1_id;
    logic             r_res_valid;
    logic [W_OUT-1:0] r_res_data;
    logic [ID_W-1:0]  r_res_id;

    logic             w_en;
    logic             w_any;
    logic             w_xfer;
    logic [ID_W-1:0]  w_gnt;
    logic [ID_W-1:0]  w_idx;
    logic [N_REQ-1:0] w_ready;
    logic [W_IN-1:0]  w_opnd;

    logic [W_PROD-1:0] w_prod;
    logic [W_T-1:0]    w_t;
    logic [W_TQ-1:0]   w_tq;
    logic [W_TQ-1:0]   w_diff;
    logic [W_R-1:0]    w_r0;
    logic [W_R-1:0]    w_r1;
    logic [W_R-1:0]    w_r2;
    logic [W_OUT-1:0]  w_res;

    assign w_en = !r_res_valid || s_bus.res_ready;

    // Scan from the farthest offset down to offset 0 so the last hit, which
    // is the one closest to r_ptr, wins. Index arithmetic wraps in ID_W bits.
    always_comb begin
        w_gnt = '0;
        w_any = 1'b0;
        w_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = r_ptr + ID_W'(k);
            if (s_bus.req_valid[w_idx]) begin
                w_gnt = w_idx;
                w_any = 1'b1;
            end
        end
    end

    // rst gating keeps every ready low while reset is held, even though
    // w_en is 1 with the result stage cleared.
    assign w_xfer = w_en && w_any && !rst;
    assign w_opnd = s_bus.req_data[int'(w_gnt) * W_IN +: W_IN];

    always_comb begin
        w_ready = '0;
        if (w_xfer) begin
            w_ready[w_gnt] = 1'b1;
        end
    end

    // Barrett step: t underestimates floor(a/Q) by at most 2, so the raw
    // remainder sits in [0, 3Q) and two conditional subtractions finish it.
    always_comb begin
        w_prod = W_PROD'(r_s1_q) * W_PROD'(MU);
        w_t    = W_T'(w_prod >> K);
        w_tq   = W_TQ'(w_t) * W_TQ'(Q);
        w_diff = W_TQ'(r_s1_a) - w_tq;
        w_r0   = W_R'(w_diff);
        w_r1   = (w_r0 >= W_R'(Q)) ? (w_r0 - W_R'(Q)) : w_r0;
        w_r2   = (w_r1 >= W_R'(Q)) ? (w_r1 - W_R'(Q)) : w_r1;
        w_res  = W_OUT'(w_r2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_q      <= '0;
            r_s1_a      <= '0;
            r_s1_id     <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_id    <= '0;
        end else if (w_en) begin
            r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_s1_q  <= W_Q1'(w_opnd >> K);
                r_s1_a  <= w_opnd;
                r_s1_id <= w_gnt;
                r_ptr   <= w_gnt + ID_W'(1);
            end
            r_res_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_res_data <= w_res;
                r_res_id   <= r_s1_id;
            end
        end
    end

    assign s_bus.req_ready = w_ready;
    assign s_bus.res_valid = r_res_valid;
    assign s_bus.res_data  = r_res_data;
    assign s_bus.res_id    = r_res_id;
    assign s_bus.idle      = !r_s1_valid && !r_res_valid;

endmodule

// File: tb/tb_barret_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_barret_rr_scheduler
// Directed and short random stimulus for barret_rr_scheduler. A cycle-level
// model (plain % arithmetic, round-robin search) predicts every output each
// cycle; literal expectations after each phase pin the model itself.
// ---------------------------------------------------------------------------
module tb_barret_rr_scheduler;
    localparam int Q     = 2213;
    localparam int N_REQ = 4;
    localparam int W_IN  = 23;
    localparam int W_OUT = 12;
    localparam int ID_W  = 2;

    logic clk = 1'b0;
    logic rst;

    barret_rr_scheduler_if #(.N_REQ(N_REQ), .W_IN(W_IN), .W_OUT(W_OUT), .ID_W(ID_W)) bus ();

    barret_rr_scheduler dut (
        .clk   (clk),
        .rst   (rst),
        .s_bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // model state
    int m_ptr = 0;
    bit m_s1_v = 1'b0;
    int m_s1_id = 0;
    int m_s1_val = 0;
    bit m_res_v = 1'b0;
    int m_res_id = 0;
    int m_res_val = 0;

    // logs of what the model says happened
    int res_log_id[$];
    int res_log_data[$];
    int pop_cyc[$];
    int gnt_log[$];
    int gnt_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        res_log_id.delete();
        res_log_data.delete();
        pop_cyc.delete();
        gnt_log.delete();
        gnt_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic set_op(input int i, input int v);
        bus.req_data[i*W_IN +: W_IN] = W_IN'(v);
    endtask

    // compare + model advance, away from the active edge
    always @(negedge clk) begin
        int g;
        int idx;
        int v;
        bit en;
        logic [N_REQ-1:0] exp_ready;
        cyc++;
        if (rst) begin
            check("rst_res_valid", bus.res_valid, 0);
            check("rst_res_data", bus.res_data, 0);
            check("rst_res_id", bus.res_id, 0);
            check("rst_idle", bus.idle, 1);
            check("rst_req_ready", bus.req_ready, 0);
            m_ptr = 0;
            m_s1_v = 1'b0;
            m_res_v = 1'b0;
        end else begin
            en = !m_res_v || bus.res_ready;
            g = -1;
            if (en) begin
                for (int off = 0; off < N_REQ; off++) begin
                    idx = (m_ptr + off) % N_REQ;
                    if (g < 0 && bus.req_valid[idx]) g = idx;
                end
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            check("req_ready", bus.req_ready, exp_ready);
            check("res_valid", bus.res_valid, m_res_v);
            if (m_res_v) begin
                check("res_data", bus.res_data, m_res_val);
                check("res_id", bus.res_id, m_res_id);
            end
            check("idle", bus.idle, (!m_s1_v && !m_res_v));
            if (m_res_v && bus.res_ready) begin
                res_log_id.push_back(m_res_id);
                res_log_data.push_back(m_res_val);
                pop_cyc.push_back(cyc);
            end
            if (en) begin
                m_res_v = m_s1_v;
                if (m_s1_v) begin
                    m_res_id = m_s1_id;
                    m_res_val = m_s1_val;
                end
                m_s1_v = (g >= 0);
                if (g >= 0) begin
                    v = int'(bus.req_data[g*W_IN +: W_IN]);
                    m_s1_id = g;
                    m_s1_val = v % Q;
                    m_ptr = (g + 1) % N_REQ;
                    gnt_log.push_back(g);
                    gnt_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ops1[5];
        int exp1[5];
        int ops4[8];
        int exp4[8];
        int exp3[7];
        int k;
        int j;

        ops1 = '{0, 2212, 2213, 4897368, 8388607};
        exp1 = '{0, 2212, 0, 2212, 1337};
        ops4 = '{4426, 100, 2300, 6639, 8388607, 5000, 2212, 9999};
        exp4 = '{0, 100, 87, 0, 1337, 574, 2212, 1147};
        exp3 = '{1, 3, 1, 3, 1, 1, 1};

        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.res_ready = 1'b1;
        step(2);
        rst = 1'b0;
        clear_logs();

        // single requester, boundary operands back-to-back
        bus.req_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            set_op(0, ops1[i]);
            step(1);
        end
        bus.req_valid = '0;
        step(4);
        check("p1_count", res_log_data.size(), 5);
        for (int i = 0; i < 5 && i < res_log_data.size(); i++) begin
            check("p1_data", res_log_data[i], exp1[i]);
            check("p1_id", res_log_id[i], 0);
        end
        if (pop_cyc.size() >= 5 && gnt_cyc.size() >= 1) begin
            check("p1_latency", pop_cyc[0] - gnt_cyc[0], 2);
            check("p1_throughput", pop_cyc[4] - pop_cyc[0], 4);
        end else begin
            check("p1_log_size", pop_cyc.size(), 5);
        end

        // all four continuously valid
        do_reset();
        bus.req_valid = 4'b1111;
        for (int i = 0; i < N_REQ; i++) set_op(i, 1000 * i + 5);
        step(8);
        bus.req_valid = '0;
        step(4);
        check("p2_count", res_log_data.size(), 8);
        for (int i = 0; i < 8 && i < res_log_data.size(); i++) begin
            check("p2_id", res_log_id[i], i % 4);
        end
        if (res_log_data.size() >= 4) begin
            check("p2_d0", res_log_data[0], 5);
            check("p2_d1", res_log_data[1], 1005);
            check("p2_d2", res_log_data[2], 2005);
            check("p2_d3", res_log_data[3], 792);
        end

        // two requesters alternate, then one alone
        do_reset();
        set_op(1, 11);
        set_op(3, 33);
        bus.req_valid = 4'b1010;
        step(4);
        bus.req_valid = 4'b0010;
        step(3);
        bus.req_valid = '0;
        step(4);
        check("p3_gnt_count", gnt_log.size(), 7);
        for (int i = 0; i < 7 && i < gnt_log.size(); i++) begin
            check("p3_gnt", gnt_log[i], exp3[i]);
        end

        // backpressure window mid-stream
        do_reset();
        k = 0;
        j = 0;
        bus.req_valid = 4'b0100;
        while (k < 8 && j < 60) begin
            bus.res_ready = !(j >= 3 && j < 8);
            set_op(2, ops4[k]);
            @(negedge clk);
            if (bus.req_ready[2]) k++;
            @(posedge clk);
            #1;
            j++;
        end
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        step(5);
        check("p4_all_accepted", k, 8);
        check("p4_count", res_log_data.size(), 8);
        for (int i = 0; i < 8 && i < res_log_data.size(); i++) begin
            check("p4_data", res_log_data[i], exp4[i]);
            check("p4_id", res_log_id[i], 2);
        end

        // reset with both stages full
        do_reset();
        bus.req_valid = 4'b1111;
        for (int i = 0; i < N_REQ; i++) set_op(i, 7000 + i);
        step(3);
        rst = 1'b1;
        #1;
        check("p5_res_valid_now", bus.res_valid, 0);
        check("p5_idle_now", bus.idle, 1);
        check("p5_ready_now", bus.req_ready, 0);
        step(1);
        rst = 1'b0;
        clear_logs();
        bus.req_valid = 4'b1100;
        set_op(2, 4426);
        set_op(3, 4426);
        step(1);
        bus.req_valid = '0;
        step(4);
        check("p5_count", res_log_data.size(), 1);
        if (res_log_data.size() >= 1) begin
            check("p5_data", res_log_data[0], 0);
            check("p5_id", res_log_id[0], 2);
        end

        // random valid/ready sweep checked cycle by cycle
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.req_valid = N_REQ'($urandom);
            for (int i = 0; i < N_REQ; i++) begin
                case ($urandom_range(5))
                    0: set_op(i, 0);
                    1: set_op(i, 23'h7FFFFF);
                    2: set_op(i, Q * $urandom_range(3789) + $urandom_range(Q - 1));
                    default: set_op(i, int'($urandom & 32'h007F_FFFF));
                endcase
            end
            bus.res_ready = ($urandom_range(3) != 0);
            step(1);
        end
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        step(4);
        check("p6_drained_idle", bus.idle, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
